pipe_scheduler: RTL and testbench

Sequences the pipe-gap datapath of the game: owns the packed gap slots consumed by the renderer and scrolls them toward the bird at a fixed tick rate. It recycles off-screen slots with freshly generated gap bounds, scores passed pipes and flags collisions with the bird's altitude. It sits between the input/scene controller, which supplies `start`, `pause` and `altitude`, and the view, which consumes `gaps`. `hit` feeds back to the controller's game-over transition.

---
 rtl/flappy_pkg.sv | 28 ++
 rtl/pipe_lfsr.sv | 22 ++
 rtl/pipe_scheduler.sv | 163 ++++++++++++++++
 tb/tb_pipe_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy pipe datapath and its controllers.
package flappy_pkg;

  localparam int unsigned GAP_W   = 24;
  localparam int unsigned POS_LSB = 16;
  localparam int unsigned MAX_LSB = 8;
  localparam int unsigned MIN_LSB = 0;

  typedef enum logic [1:0] {
    SCENE_SPLASH   = 2'd0,
    SCENE_PLAYING  = 2'd1,
    SCENE_GAMEOVER = 2'd2
  } scene_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // One gap slot as seen by the renderer: {position, max_bnd, min_bnd}.
  typedef struct packed {
    logic [7:0] pos;
    logic [7:0] max_bnd;
    logic [7:0] min_bnd;
  } gap_t;

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping every clock; feeds recycled gap bounds.
module pipe_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls, recycles and scores the pipe gap slots and flags bird collisions.
// Define PIPE_SCHEDULER_RANDOM_EN to draw recycled gap bounds from an LFSR.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int unsigned SLOTS    = 3,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned SPACING  = 20,
  parameter int unsigned GAP_H    = 10,
  parameter int unsigned ALT_MAX  = 38,
  parameter int unsigned BIRD_COL = 4,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   pause,
  input  logic [7:0]             altitude,
  output logic [GAP_W*SLOTS-1:0] gaps,
  output logic [7:0]             score,
  output logic                   hit,
  output logic                   running
);

  localparam int unsigned     CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]      INIT_MIN    = 8'd14;
  localparam logic [7:0]      INIT_MAX    = 8'(14 + GAP_H);
  localparam logic [7:0]      RECYCLE_POS = 8'(SLOTS * SPACING - 1);
  localparam logic [7:0]      BND_LIM     = 8'(ALT_MAX - GAP_H);

  sched_state_e          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            score_q;
  logic                  hit_q;
  logic                  running_q;
  gap_t [SLOTS-1:0]      slot_q;
  gap_t [SLOTS-1:0]      slot_d;

  logic       collide;
  logic       at_bird;
  logic       tick;
  logic [7:0] new_min;
  logic [7:0] new_max;

  function automatic gap_t init_slot(input int unsigned idx);
    gap_t g;
    g.pos     = 8'((idx + 1) * SPACING);
    g.max_bnd = INIT_MAX;
    g.min_bnd = INIT_MIN;
    return g;
  endfunction

`ifdef PIPE_SCHEDULER_RANDOM_EN
  logic [7:0] lfsr;
  logic [7:0] raw_min;
  logic       unused_lfsr;

  pipe_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // Candidates above the legal band fold back down by 16 to stay reachable.
  always_comb begin
    raw_min = 8'd2 + {3'd0, lfsr[4:0]};
    new_min = (raw_min > BND_LIM) ? raw_min - 8'd16 : raw_min;
  end
  assign unused_lfsr = ^lfsr[7:5];
`else
  logic unused_seed;
  logic [7:0] unused_lim;
  assign new_min     = INIT_MIN;
  assign unused_seed = ^SEED;
  assign unused_lim  = BND_LIM;
`endif

  assign new_max = new_min + 8'(GAP_H);

  // Collision and bird-column occupancy on the current (pre-update) slots.
  always_comb begin
    collide = (altitude == 8'd0) || (altitude > 8'(ALT_MAX));
    at_bird = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (slot_q[i].pos == 8'(BIRD_COL)) begin
        at_bird = 1'b1;
        if ((altitude <= slot_q[i].min_bnd) || (altitude >= slot_q[i].max_bnd)) collide = 1'b1;
      end
    end
  end

  assign tick = (state_q == ST_RUN) && !pause && !collide && (cnt_q == CNT_LAST);

  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (slot_q[i].pos == 8'd0) begin
          slot_d[i].pos     = RECYCLE_POS;
          slot_d[i].max_bnd = new_max;
          slot_d[i].min_bnd = new_min;
        end else begin
          slot_d[i].pos = slot_q[i].pos - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      score_q   <= '0;
      hit_q     <= 1'b0;
      running_q <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) slot_q[i] <= init_slot(i);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (collide) begin
            state_q   <= ST_DONE;
            hit_q     <= 1'b1;
            running_q <= 1'b0;
          end else if (!pause) begin
            cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
            slot_q <= slot_d;
            if (tick && at_bird && (score_q != 8'hFF)) score_q <= score_q + 8'd1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) slot_q[i] <= init_slot(i);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign gaps[GAP_W*(SLOTS-g)-1 -: GAP_W] = slot_q[g];
  end

  assign score   = score_q;
  assign hit     = hit_q;
  assign running = running_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler: directed scenarios plus random play against a game-rule model.
module tb_pipe_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [7:0]  altitude = 8'd19;
  logic [71:0] gaps;
  logic [7:0]  score;
  logic        hit;
  logic        running;

  int checks = 0;
  int failures = 0;

  localparam logic [71:0] INIT_GAPS = 72'h14180E_28180E_3C180E;

  always #5 clk = ~clk;

  pipe_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .altitude (altitude),
    .gaps     (gaps),
    .score    (score),
    .hit      (hit),
    .running  (running)
  );

  // Game-rule model: mode 0=waiting, 1=playing, 2=game over.
  int m_pos[3];
  int m_min[3];
  int m_max[3];
  int m_score, m_hit, m_mode, m_cnt, m_lfsr;

  task automatic model_layout();
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = (i + 1) * 20;
      m_min[i] = 14;
      m_max[i] = 24;
    end
  endtask

  task automatic model_step(input bit s, input bit p, input int a, input bit r);
    int  fb, nl, raw;
    bit  coll, passed;
    if (!r) begin
      m_mode = 0; m_cnt = 0; m_score = 0; m_hit = 0; m_lfsr = 8'hA5;
      model_layout();
    end else begin
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      nl = ((m_lfsr << 1) | fb) & 255;
      if (m_mode == 0) begin
        m_cnt = 0;
        if (s) m_mode = 1;
      end else if (m_mode == 1) begin
        coll = (a == 0) || (a > 38);
        for (int i = 0; i < 3; i++)
          if (m_pos[i] == 4 && (a <= m_min[i] || a >= m_max[i])) coll = 1;
        if (coll) begin
          m_hit = 1; m_mode = 2;
        end else if (!p) begin
          if (m_cnt == 3) begin
            passed = 0;
            for (int i = 0; i < 3; i++) begin
              if (m_pos[i] == 4) passed = 1;
              if (m_pos[i] == 0) begin
                m_pos[i] = 59;
`ifdef PIPE_SCHEDULER_RANDOM_EN
                raw = 2 + (m_lfsr % 32);
                m_min[i] = (raw > 28) ? raw - 16 : raw;
`else
                raw = 14;
                m_min[i] = raw;
`endif
                m_max[i] = m_min[i] + 10;
              end else begin
                m_pos[i] = m_pos[i] - 1;
              end
            end
            if (passed && m_score < 255) m_score++;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
      end else if (s) begin
        m_mode = 0; m_score = 0; m_hit = 0; m_cnt = 0;
        model_layout();
      end
      m_lfsr = nl;
    end
  endtask

  function automatic logic [71:0] model_gaps();
    logic [71:0] r;
    for (int i = 0; i < 3; i++)
      r[71-24*i -: 24] = {8'(m_pos[i]), 8'(m_max[i]), 8'(m_min[i])};
    return r;
  endfunction

  task automatic cycle(input bit s, input bit p, input logic [7:0] a, input bit r);
    @(negedge clk);
    start = s; pause = p; altitude = a; rst_n = r;
    @(posedge clk);
    model_step(s, p, int'(a), r);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 8'd19, 0);
    cycle(0, 0, 8'd19, 0);
    checks++; if (gaps !== INIT_GAPS) begin failures++; $display("FAIL reset_gaps got=%h exp=%h", gaps, INIT_GAPS); end
    checks++; if (score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    cycle(0, 0, 8'd19, 1);
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL idle_running got=%b exp=0", running); end
  endtask

  task automatic test_start_first_tick();
    cycle(1, 0, 8'd19, 1);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 0, 8'd19, 1);
      checks++; if (gaps !== INIT_GAPS) begin failures++; $display("FAIL pre_tick_gaps c=%0d got=%h exp=%h", k, gaps, INIT_GAPS); end
    end
    cycle(0, 0, 8'd19, 1);
    checks++; if (gaps !== 72'h13180E_27180E_3B180E) begin failures++; $display("FAIL first_tick_gaps got=%h exp=13180e27180e3b180e", gaps); end
  endtask

  // Continues from the first tick (cycle 4 of RUN) with a safe altitude up to score 3.
  task automatic test_recycle_score();
    for (int c = 5; c <= 228; c++) begin
      cycle(0, 0, 8'd19, 1);
      checks++; if (gaps !== model_gaps()) begin failures++; $display("FAIL run_gaps c=%0d got=%h exp=%h", c, gaps, model_gaps()); end
      checks++; if (hit !== 1'b0) begin failures++; $display("FAIL run_hit c=%0d got=%b exp=0", c, hit); end
      if (c == 67) begin
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL score_before c=%0d got=%0d exp=0", c, score); end
      end
      if (c == 68) begin
        checks++; if (score !== 8'd1) begin failures++; $display("FAIL score_first c=%0d got=%0d exp=1", c, score); end
      end
      if (c == 84) begin
        checks++; if ({gaps[71:64], gaps[47:40], gaps[23:16]} !== {8'd59, 8'd19, 8'd39})
          begin failures++; $display("FAIL recycle_pos got=%0d/%0d/%0d exp=59/19/39", gaps[71:64], gaps[47:40], gaps[23:16]); end
`ifdef PIPE_SCHEDULER_RANDOM_EN
        checks++; if ({gaps[63:56], gaps[55:48]} !== {8'(m_max[0]), 8'(m_min[0])})
          begin failures++; $display("FAIL recycle_bnd got=%0d/%0d exp=%0d/%0d", gaps[55:48], gaps[63:56], m_min[0], m_max[0]); end
`else
        checks++; if ({gaps[63:56], gaps[55:48]} !== {8'd24, 8'd14})
          begin failures++; $display("FAIL recycle_bnd got=%0d/%0d exp=14/24", gaps[55:48], gaps[63:56]); end
`endif
      end
      if (c == 148) begin
        checks++; if (score !== 8'd2) begin failures++; $display("FAIL score_second got=%0d exp=2", score); end
      end
      if (c == 228) begin
        checks++; if (score !== 8'd3) begin failures++; $display("FAIL score_third got=%0d exp=3", score); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    cycle(0, 0, 8'd19, 0);
    checks++; if (score !== 8'd0) begin failures++; $display("FAIL midrst_score got=%0d exp=0", score); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL midrst_running got=%b exp=0", running); end
    checks++; if (gaps !== INIT_GAPS) begin failures++; $display("FAIL midrst_gaps got=%h exp=%h", gaps, INIT_GAPS); end
    cycle(0, 0, 8'd19, 1);
  endtask

  task automatic test_collision();
    cycle(1, 0, 8'd19, 1);
    repeat (64) cycle(0, 0, 8'd19, 1);
    checks++; if (gaps[71:64] !== 8'd4) begin failures++; $display("FAIL coll_setup_pos got=%0d exp=4", gaps[71:64]); end
    cycle(0, 0, 8'd30, 1);
    checks++; if ({hit, running} !== 2'b10) begin failures++; $display("FAIL coll_flags got=%b%b exp=10", hit, running); end
    checks++; if (score !== 8'd0) begin failures++; $display("FAIL coll_score got=%0d exp=0", score); end
    repeat (6) begin
      cycle(0, 0, 8'd30, 1);
      checks++; if (gaps !== 72'h04180E_18180E_2C180E) begin failures++; $display("FAIL done_frozen got=%h exp=04180e18180e2c180e", gaps); end
    end
    cycle(1, 0, 8'd19, 1);
    checks++; if ({hit, running, score} !== 10'd0) begin failures++; $display("FAIL done_exit hit=%b run=%b score=%0d exp=0/0/0", hit, running, score); end
    checks++; if (gaps !== INIT_GAPS) begin failures++; $display("FAIL done_exit_gaps got=%h exp=%h", gaps, INIT_GAPS); end
  endtask

  task automatic test_pause();
    cycle(1, 0, 8'd19, 1);
    repeat (8) cycle(0, 0, 8'd19, 1);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 8'd19, 1);
      checks++; if (gaps !== 72'h12180E_26180E_3A180E) begin failures++; $display("FAIL pause_gaps k=%0d got=%h exp=12180e26180e3a180e", k, gaps); end
    end
    cycle(0, 1, 8'd0, 1);
    checks++; if ({hit, running} !== 2'b10) begin failures++; $display("FAIL pause_ground got=%b%b exp=10", hit, running); end
    cycle(1, 0, 8'd19, 1);
  endtask

  task automatic test_start_held();
    cycle(1, 0, 8'd19, 1);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL held_run got=%b exp=1", running); end
    cycle(1, 0, 8'd19, 1);
    checks++; if ({hit, running} !== 2'b01) begin failures++; $display("FAIL held_stay got=%b%b exp=01", hit, running); end
    cycle(1, 0, 8'd50, 1);
    checks++; if ({hit, running} !== 2'b10) begin failures++; $display("FAIL held_high_alt got=%b%b exp=10", hit, running); end
    cycle(1, 0, 8'd19, 1);
    checks++; if ({hit, running} !== 2'b00) begin failures++; $display("FAIL held_to_idle got=%b%b exp=00", hit, running); end
    cycle(1, 0, 8'd19, 1);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL held_rerun got=%b exp=1", running); end
  endtask

  task automatic test_random();
    bit s, p, r;
    logic [7:0] a;
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 60)) : 8'($urandom_range(12, 26));
      cycle(s, p, a, r);
      checks++; if (gaps !== model_gaps()) begin failures++; $display("FAIL rnd_gaps c=%0d got=%h exp=%h", c, gaps, model_gaps()); end
      checks++; if (score !== 8'(m_score)) begin failures++; $display("FAIL rnd_score c=%0d got=%0d exp=%0d", c, score, m_score); end
      checks++; if (hit !== 1'(m_hit)) begin failures++; $display("FAIL rnd_hit c=%0d got=%b exp=%0d", c, hit, m_hit); end
      checks++; if (running !== (m_mode == 1)) begin failures++; $display("FAIL rnd_running c=%0d got=%b exp=%0d", c, running, m_mode == 1); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_first_tick();
    test_recycle_score();
    test_reset_midrun();
    test_collision();
    test_pause();
    test_start_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
